// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle main control unit: opcodes, FSM states,
// datapath select codes and the per-state control vector.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_EXT   = 2'b10;
  localparam logic [1:0] SRCB_EXTSH = 2'b11;

  // memwait marks states that stall on MemRdy; last marks retiring states
  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       iord;
    logic       dmwe;
    logic       irwe;
    logic       rfwe;
    logic       rfdsel;
    logic       mtorfsel;
    logic       aluinsel;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       branch;
    logic       memwait;
    logic       last;
  } ctl_t;

endpackage

// File: rtl/mc_state_decode.sv
// Moore output decode: registered state -> raw datapath control vector.
module mc_state_decode
  import mc_pkg::*;
(
  input  state_t state,
  output ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.irwe    = 1'b1;
        ctl.alusrcb = SRCB_FOUR;
        ctl.pcsrc   = PC_ALU;
        ctl.pcwrite = 1'b1;
        ctl.memwait = 1'b1;
      end
      S_DECODE: ctl.alusrcb = SRCB_EXTSH;
      S_MEMADR, S_ADDIEX: begin
        ctl.aluinsel = 1'b1;
        ctl.alusrcb  = SRCB_EXT;
      end
      S_MEMRD: begin
        ctl.iord    = 1'b1;
        ctl.memwait = 1'b1;
      end
      S_MEMWB: begin
        ctl.rfwe     = 1'b1;
        ctl.mtorfsel = 1'b1;
        ctl.last     = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord    = 1'b1;
        ctl.dmwe    = 1'b1;
        ctl.memwait = 1'b1;
        ctl.last    = 1'b1;
      end
      S_EXEC: begin
        ctl.aluinsel = 1'b1;
        ctl.alusrcb  = SRCB_RD2;
        ctl.aluop    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctl.rfwe   = 1'b1;
        ctl.rfdsel = 1'b1;
        ctl.last   = 1'b1;
      end
      S_BEQ: begin
        ctl.aluinsel = 1'b1;
        ctl.alusrcb  = SRCB_RD2;
        ctl.aluop    = ALU_SUB;
        ctl.branch   = 1'b1;
        ctl.pcsrc    = PC_ALUOUT;
        ctl.last     = 1'b1;
      end
      S_ADDIWB: begin
        ctl.rfwe = 1'b1;
        ctl.last = 1'b1;
      end
      S_JUMP: begin
        ctl.pcsrc   = PC_JUMP;
        ctl.pcwrite = 1'b1;
        ctl.last    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset main control: next-state sequencing, reset gating of
// write strobes, retire pulse/counter and the PCWE branch OR.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b0,
  parameter bit EN_JUMP     = 1'b1,
  parameter bit EN_ADDI     = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Opcode,
  input  logic             Zero,
  input  logic             MemRdy,
  output logic             PCWE,
  output logic [1:0]       PCSrc,
  output logic             IorD,
  output logic             DMWE,
  output logic             IRWE,
  output logic             RFWE,
  output logic             RFDSel,
  output logic             MtoRFSel,
  output logic             ALUInSel,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             Branch,
  output logic             Retire,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [3:0]       State
);

  state_t state, state_nxt;
  ctl_t   ctl;
  logic   legal, stall;

  mc_state_decode u_dec (.state(state), .ctl(ctl));

  always_comb begin
    case (Opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: legal = 1'b1;
      OP_ADDI:                        legal = EN_ADDI;
      OP_J:                           legal = EN_JUMP;
      default:                        legal = 1'b0;
    endcase
  end

  assign stall = MEM_WAIT_EN && ctl.memwait && !MemRdy;

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (!legal) state_nxt = S_FETCH;
        else begin
          case (Opcode)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_BEQ:       state_nxt = S_BEQ;
            OP_ADDI:      state_nxt = S_ADDIEX;
            OP_J:         state_nxt = S_JUMP;
            default:      state_nxt = S_EXEC;
          endcase
        end
      end
      S_MEMADR: state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
    if (stall) state_nxt = state;
  end

  // a waiting MEMWR keeps its strobes but retires only on the advancing cycle
  assign Retire    = ctl.last && !stall && !RST;
  assign IllegalOp = (state == S_DECODE) && !legal && !RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_FETCH;
      RetireCnt <= '0;
    end else begin
      state <= state_nxt;
      if (Retire) RetireCnt <= RetireCnt + CNT_W'(1);
    end
  end

  assign PCWE     = !RST && (ctl.pcwrite || (ctl.branch && Zero));
  assign IRWE     = !RST && ctl.irwe;
  assign DMWE     = !RST && ctl.dmwe;
  assign RFWE     = !RST && ctl.rfwe;
  assign PCSrc    = ctl.pcsrc;
  assign IorD     = ctl.iord;
  assign RFDSel   = ctl.rfdsel;
  assign MtoRFSel = ctl.mtorfsel;
  assign ALUInSel = ctl.aluinsel;
  assign ALUSrcB  = ctl.alusrcb;
  assign ALUOp    = ctl.aluop;
  assign Branch   = ctl.branch;
  assign State    = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized instruction-stream bench for mc_control_unit against a per-instruction
// cycle-list model; dut0 uses defaults, dut1 uses memory waits, no j/addi, 4-bit count.
module tb_mc_control_unit;

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                 EX = 6, AWB = 7, BQ = 8, AE = 9, AIW = 10, JP = 11;

  typedef struct packed {
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       iord, dmwe, irwe, rfwe, rfdsel, mtorfsel, aluinsel;
    logic [1:0] alusrcb, aluop;
    logic       branch, retire, illegal;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    int st;
    bit rdy, ret, ill, rs, z;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst[2];
  logic [5:0]  opc[2];
  logic        zero[2], rdy[2];
  obs_t        obs[2];
  logic [31:0] cnt[2];

  bit          chk[2];
  ent_t        cur[2];
  int          ecnt[2];
  int          dmwe_cyc[2];
  int          checks = 0, errors = 0;
  ent_t        sq[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = (g == 0) ? 32 : 4;
    logic pcwe, iord, dmwe, irwe, rfwe, rfdsel, mtorfsel, aluinsel, branch, retire, illegal;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic [3:0] state;
    logic [CW-1:0] c;
    mc_control_unit #(.MEM_WAIT_EN(g == 1), .EN_JUMP(g == 0), .EN_ADDI(g == 0), .CNT_W(CW)) u_dut (
      .CLK(clk), .RST(rst[g]), .Opcode(opc[g]), .Zero(zero[g]), .MemRdy(rdy[g]),
      .PCWE(pcwe), .PCSrc(pcsrc), .IorD(iord), .DMWE(dmwe), .IRWE(irwe), .RFWE(rfwe),
      .RFDSel(rfdsel), .MtoRFSel(mtorfsel), .ALUInSel(aluinsel), .ALUSrcB(alusrcb),
      .ALUOp(aluop), .Branch(branch), .Retire(retire), .IllegalOp(illegal),
      .RetireCnt(c), .State(state));
    assign obs[g] = {pcwe, pcsrc, iord, dmwe, irwe, rfwe, rfdsel, mtorfsel, aluinsel,
                     alusrcb, aluop, branch, retire, illegal, state};
    assign cnt[g] = 32'(c);
  end

  // Expected outputs straight from the per-state control table
  function automatic obs_t exp_out(ent_t e);
    obs_t o = '0;
    bit pcw = 1'b0;
    case (e.st)
      FE:  begin o.irwe = 1; o.alusrcb = 2'b01; pcw = 1; end
      DE:  o.alusrcb = 2'b11;
      MA:  begin o.aluinsel = 1; o.alusrcb = 2'b10; end
      MR:  o.iord = 1;
      MWB: begin o.rfwe = 1; o.mtorfsel = 1; end
      MW:  begin o.iord = 1; o.dmwe = 1; end
      EX:  begin o.aluinsel = 1; o.aluop = 2'b10; end
      AWB: begin o.rfwe = 1; o.rfdsel = 1; end
      BQ:  begin o.aluinsel = 1; o.aluop = 2'b01; o.branch = 1; o.pcsrc = 2'b01; end
      AE:  begin o.aluinsel = 1; o.alusrcb = 2'b10; end
      AIW: o.rfwe = 1;
      JP:  begin o.pcsrc = 2'b10; pcw = 1; end
      default: ;
    endcase
    o.pcwe = pcw | (o.branch & e.z);
    if (e.rs) begin o.pcwe = 0; o.irwe = 0; o.dmwe = 0; o.rfwe = 0; end
    o.retire  = e.ret;
    o.illegal = e.ill;
    o.state   = 4'(e.st);
    return o;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (chk[k]) begin
        obs_t e;
        logic [31:0] ec;
        e  = exp_out(cur[k]);
        ec = (k == 1) ? (32'(ecnt[k]) & 32'hF) : 32'(ecnt[k]);
        checks++;
        if (obs[k] !== e) begin
          errors++;
          $display("FAIL ctl dut%0d st=%0d: got %h want %h", k, cur[k].st, obs[k], e);
        end
        checks++;
        if (cnt[k] !== ec) begin
          errors++;
          $display("FAIL retirecnt dut%0d: got %0d want %0d", k, cnt[k], ec);
        end
        if (obs[k].dmwe === 1'b1) dmwe_cyc[k]++;
      end
    end
  end

  task automatic check_lit(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic bit is_legal(int k, logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100: return 1'b1;
      6'b001000, 6'b000010: return (k == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(int st, bit r, bit ret, bit ill);
    ent_t e;
    e.st = st; e.rdy = r; e.ret = ret; e.ill = ill; e.rs = 1'b0; e.z = 1'($urandom);
    sq.push_back(e);
  endtask

  // memory-wait states: dut1 holds for n cycles with MemRdy low, dut0 ignores MemRdy
  task automatic push_mem(int k, int st, int n, bit fin);
    if (k == 1) begin
      repeat (n) push(st, 1'b0, 1'b0, 1'b0);
      push(st, 1'b1, fin, 1'b0);
    end else push(st, 1'($urandom), fin, 1'b0);
  endtask

  task automatic build(int k, logic [5:0] op, int nf, int nm);
    sq.delete();
    push_mem(k, FE, nf, 1'b0);
    push(DE, 1'($urandom), 1'b0, !is_legal(k, op));
    if (is_legal(k, op)) begin
      case (op)
        6'b100011: begin push(MA, 1'($urandom), 0, 0); push_mem(k, MR, nm, 1'b0); push(MWB, 1'($urandom), 1, 0); end
        6'b101011: begin push(MA, 1'($urandom), 0, 0); push_mem(k, MW, nm, 1'b1); end
        6'b000100: push(BQ, 1'($urandom), 1, 0);
        6'b001000: begin push(AE, 1'($urandom), 0, 0); push(AIW, 1'($urandom), 1, 0); end
        6'b000010: push(JP, 1'($urandom), 1, 0);
        default:   begin push(EX, 1'($urandom), 0, 0); push(AWB, 1'($urandom), 1, 0); end
      endcase
    end
  endtask

  task automatic run(int k, logic [5:0] op, int n);
    for (int i = 0; i < n; i++) begin
      cur[k] = sq[i]; opc[k] = op; zero[k] = sq[i].z; rdy[k] = sq[i].rdy; chk[k] = 1'b1;
      @(posedge clk);
      if (sq[i].ret) ecnt[k]++;
      #1;
    end
  endtask

  task automatic instr(int k, logic [5:0] op, int nf, int nm);
    build(k, op, nf, nm);
    run(k, op, sq.size());
  endtask

  task automatic do_reset(int k, int n);
    rst[k] = 1'b1; ecnt[k] = 0; chk[k] = 1'b1;
    cur[k].st = FE; cur[k].rdy = 1'b1; cur[k].ret = 1'b0; cur[k].ill = 1'b0; cur[k].rs = 1'b1;
    repeat (n) begin
      cur[k].z = 1'($urandom); zero[k] = cur[k].z; rdy[k] = 1'($urandom);
      @(posedge clk); #1;
    end
    rst[k] = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 6))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; opc[k] = '0; zero[k] = 1'b0; rdy[k] = 1'b1; chk[k] = 1'b0;
      ecnt[k] = 0; dmwe_cyc[k] = 0;
    end
    @(posedge clk); #1;

    // dut0: default configuration
    do_reset(0, 2);
    build(0, 6'b100011, 0, 0);
    check_lit("lw_cycles", sq.size(), 5);
    run(0, 6'b100011, sq.size());
    check_lit("lw_retirecnt", int'(cnt[0]), 1);
    for (int zb = 1; zb >= 0; zb--) begin
      build(0, 6'b000100, 0, 0);
      check_lit("beq_cycles", sq.size(), 3);
      sq[2].z = 1'(zb);
      run(0, 6'b000100, sq.size());
    end
    check_lit("beq_retirecnt", int'(cnt[0]), 3);
    build(0, 6'b111111, 0, 0);
    check_lit("illegal_cycles", sq.size(), 2);
    run(0, 6'b111111, sq.size());
    check_lit("illegal_retirecnt", int'(cnt[0]), 3);
    instr(0, 6'b000010, 0, 0);
    instr(0, 6'b001000, 0, 0);
    instr(0, 6'b101011, 2, 2);
    for (int i = 0; i < 80; i++) instr(0, rand_op(), $urandom_range(0, 2), $urandom_range(0, 2));
    chk[0] = 1'b0; rst[0] = 1'b1;

    // dut1: memory waits, j/addi disabled, 4-bit counter
    do_reset(1, 2);
    build(1, 6'b101011, 0, 3);
    check_lit("sw_wait_cycles", sq.size(), 7);
    dmwe_cyc[1] = 0;
    run(1, 6'b101011, sq.size());
    check_lit("sw_dmwe_held", dmwe_cyc[1], 4);
    check_lit("sw_retirecnt", int'(cnt[1]), 1);
    instr(1, 6'b000010, 0, 0);
    instr(1, 6'b001000, 0, 0);
    check_lit("j_addi_illegal_cnt", int'(cnt[1]), 1);
    instr(1, 6'b100011, 2, 1);
    for (int i = 0; i < 60; i++) instr(1, rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    do_reset(1, 2);
    for (int i = 0; i < 16; i++) instr(1, 6'b000000, 0, 0);
    check_lit("wrap_retirecnt", int'(cnt[1]), 0);
    for (int i = 0; i < 3; i++) instr(1, 6'b000000, 0, 0);
    check_lit("pre_abort_cnt", int'(cnt[1]), 3);

    // abort an R-type in EXEC with an asynchronous reset
    build(1, 6'b000000, 0, 0);
    run(1, 6'b000000, 2);
    cur[1] = sq[2]; zero[1] = sq[2].z; rdy[1] = sq[2].rdy;
    @(negedge clk); #1;
    rst[1] = 1'b1; ecnt[1] = 0;
    cur[1].st = FE; cur[1].ret = 1'b0; cur[1].ill = 1'b0; cur[1].rs = 1'b1;
    #1;
    check_lit("abort_cnt_cleared", int'(cnt[1]), 0);
    check_lit("abort_no_retire", int'(obs[1].retire), 0);
    @(posedge clk); #1;
    do_reset(1, 2);
    instr(1, 6'b000000, 0, 0);
    check_lit("post_abort_cnt", int'(cnt[1]), 1);
    chk[1] = 1'b0;

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
